// File: rtl/display_bcd_converter_pkg.sv
// Shared definitions for the display binary-to-BCD converter.
//   state_e        : converter FSM encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//   BCD_NINE       : digit pattern shown on every position when the value saturates
//   DEFAULT_IN_W   : default binary input width used by the Computer top
//   DEFAULT_DIGITS : default number of displayed BCD digits
package display_bcd_converter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;

  localparam int unsigned DEFAULT_IN_W   = 16;
  localparam int unsigned DEFAULT_DIGITS = 4;

endpackage

// File: rtl/display_bcd_converter_bcd_add3.sv
// bcd_add3: one combinational double-dabble correction cell.
//   din  : 4-bit BCD digit before the shift
//   dout : din + 3 when din >= 5, otherwise din
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/display_bcd_converter.sv
// display_bcd_converter: sequential binary-to-BCD converter (shift-add-3) feeding the
// seven-segment driver. The previous result stays on bcd while a new conversion runs.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   num      : binary value to display
//   bcd      : BCD digits, digit 0 in bcd[3:0]
//   valid    : bcd holds a completed conversion
//   busy     : conversion in progress (LOAD, SHIFT, DONE)
//   overflow : last value exceeded 10^DIGITS-1 (bcd then shows all nines)
//   neg      : last value was negative
// Optional feature: define BCD_SIGNED_EN to treat num as two's complement; without it num is
// unsigned and neg is tied low.
module display_bcd_converter
  import display_bcd_converter_pkg::*;
#(
  parameter int unsigned IN_W   = DEFAULT_IN_W,
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       num,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy,
  output logic                  overflow,
  output logic                  neg
);

  // Enough internal digits that any IN_W-bit value converts without loss.
  localparam int unsigned INT_DIGITS = (IN_W + 2) / 3;
  localparam int unsigned BCD_W      = INT_DIGITS * 4;
  localparam int unsigned SR_W       = BCD_W + IN_W;
  localparam int unsigned CNT_W      = $clog2(IN_W + 1);
  localparam int unsigned EXT_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;

  state_e               state_q, state_d;
  logic [IN_W-1:0]      last_num_q;
  logic                 first_pending_q;
  logic [SR_W-1:0]      sr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic                 valid_q;
  logic                 overflow_q;
  logic                 capture;
  logic [IN_W-1:0]      operand;
  logic [BCD_W-1:0]     bcd_adj;
  logic [SR_W-1:0]      sr_shift;
  logic [EXT_DIGITS*4-1:0] digits_ext;
  logic                 hi_nz;

  assign capture = first_pending_q || (num != last_num_q);

`ifdef BCD_SIGNED_EN
  logic neg_q;
  // Magnitude of the captured value; the most negative input maps to 2^(IN_W-1).
  assign operand = last_num_q[IN_W-1] ? (~last_num_q + IN_W'(1)) : last_num_q;
  assign neg     = neg_q;
`else
  assign operand = last_num_q;
  assign neg     = 1'b0;
`endif

  // Correct every BCD digit, then shift the whole register left by one.
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr_q[IN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end
  assign sr_shift = {bcd_adj[BCD_W-2:0], sr_q[IN_W-1:0], 1'b0};

  always_comb begin
    digits_ext = '0;
    digits_ext[BCD_W-1:0] = sr_q[SR_W-1:IN_W];
  end

  if (EXT_DIGITS > DIGITS) begin : g_ovf
    assign hi_nz = |digits_ext[EXT_DIGITS*4-1:DIGITS*4];
  end else begin : g_no_ovf
    assign hi_nz = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (cnt_q == CNT_W'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    if (state_q != StIdle) busy = 1'b1;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_num_q      <= '0;
      first_pending_q <= 1'b1;
      sr_q            <= '0;
      cnt_q           <= '0;
      bcd_q           <= '0;
      valid_q         <= 1'b0;
      overflow_q      <= 1'b0;
`ifdef BCD_SIGNED_EN
      neg_q           <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture) last_num_q <= num;
        end
        StLoad: begin
          sr_q  <= {{BCD_W{1'b0}}, operand};
          cnt_q <= CNT_W'(IN_W);
        end
        StShift: begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        StDone: begin
          first_pending_q <= 1'b0;
          valid_q         <= 1'b1;
          overflow_q      <= hi_nz;
          bcd_q           <= hi_nz ? {DIGITS{BCD_NINE}} : digits_ext[4*DIGITS-1:0];
`ifdef BCD_SIGNED_EN
          neg_q           <= last_num_q[IN_W-1];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_display_bcd_converter.sv
module tb_display_bcd_converter;

  localparam int unsigned IN_W   = 16;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned LAT    = IN_W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] num;
  logic [15:0] bcd;
  logic        valid, busy, overflow, neg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_bcd_converter #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .bcd      (bcd),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow),
    .neg      (neg)
  );

  // Reference: decimal value of the operand, saturated to 9999.
  function automatic void ref_model(input logic [15:0] n, output logic [15:0] e_bcd,
                                    output logic e_ovf, output logic e_neg);
    int v;
    v     = int'(n);
    e_neg = 1'b0;
`ifdef BCD_SIGNED_EN
    if (n[15]) begin
      v     = 65536 - int'(n);
      e_neg = 1'b1;
    end
`endif
    if (v > 9999) begin
      e_bcd = 16'h9999;
      e_ovf = 1'b1;
    end else begin
      e_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e_ovf = 1'b0;
    end
  endfunction

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    num = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bcd !== 16'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (neg !== 1'b0) begin bad++; $display("FAIL reset_neg got=%b exp=0", neg); end
    rst = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    total++; if (cyc != 18) begin bad++; $display("FAIL first_busy_len got=%0d exp=18", cyc); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", valid); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL first_bcd got=%h exp=0000", bcd); end
  endtask

  task automatic test_latency();
    logic [15:0] old;
    int          errs;
    old  = bcd;
    errs = 0;
    num  = 16'd1234;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || bcd !== old) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL hold_during_busy got=%0d_bad_cycles exp=0", errs); end
    @(negedge clk);
    total++; if (bcd !== 16'h1234) begin bad++; $display("FAIL lat_bcd got=%h exp=1234", bcd); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL lat_ovf got=%b exp=0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_busy got=%b exp=0", busy); end
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [4];
    logic [15:0] e_bcd;
    logic        e_ovf, e_neg;
    vals[0] = 16'd9999;
    vals[1] = 16'd10000;
    vals[2] = 16'd65535;
    vals[3] = 16'd0;
    foreach (vals[i]) begin
      num = vals[i];
      repeat (LAT + 1) @(negedge clk);
      ref_model(vals[i], e_bcd, e_ovf, e_neg);
      total++; if (bcd !== e_bcd) begin bad++; $display("FAIL bound_bcd num=%0d got=%h exp=%h", vals[i], bcd, e_bcd); end
      total++; if (overflow !== e_ovf) begin bad++; $display("FAIL bound_ovf num=%0d got=%b exp=%b", vals[i], overflow, e_ovf); end
      total++; if (neg !== e_neg) begin bad++; $display("FAIL bound_neg num=%0d got=%b exp=%b", vals[i], neg, e_neg); end
    end
  endtask

  task automatic test_change_during_busy();
    num = 16'd42;
    repeat (5) @(negedge clk);
    num = 16'd77;
    repeat (LAT + 1 - 5) @(negedge clk);
    total++; if (bcd !== 16'h0042) begin bad++; $display("FAIL chg_first got=%h exp=0042", bcd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL chg_idle got=%b exp=0", busy); end
    repeat (LAT) @(negedge clk);
    total++; if (bcd !== 16'h0042 || busy !== 1'b1) begin
      bad++; $display("FAIL chg_hold got=%h/%b exp=0042/1", bcd, busy);
    end
    @(negedge clk);
    total++; if (bcd !== 16'h0077) begin bad++; $display("FAIL chg_second got=%h exp=0077", bcd); end
  endtask

  task automatic test_reset_mid();
    num = 16'd500;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b0 || bcd !== 16'h0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_abort got=v%b/%h/b%b/o%b exp=v0/0000/b0/o0", valid, bcd, busy, overflow);
    end
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_early_valid got=%b exp=0", valid); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || bcd !== 16'h0500) begin
      bad++; $display("FAIL mid_reconv got=v%b/%h exp=v1/0500", valid, bcd);
    end
  endtask

  task automatic test_random();
    logic [15:0] n, e_bcd;
    logic        e_ovf, e_neg;
    for (int i = 0; i < 40; i++) begin
      n = 16'($urandom);
      if ($urandom_range(0, 1) == 1) n = 16'($urandom_range(0, 9999));
      num = n;
      repeat (LAT + 1) @(negedge clk);
      ref_model(n, e_bcd, e_ovf, e_neg);
      total++; if (bcd !== e_bcd || overflow !== e_ovf || neg !== e_neg || valid !== 1'b1) begin
        bad++;
        $display("FAIL rand num=%h got=%h/o%b/n%b/v%b exp=%h/o%b/n%b/v1", n, bcd, overflow, neg,
                 valid, e_bcd, e_ovf, e_neg);
      end
    end
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed();
    num = 16'hFFFF;
    repeat (LAT + 1) @(negedge clk);
    total++; if (neg !== 1'b1 || bcd !== 16'h0001 || overflow !== 1'b0) begin
      bad++; $display("FAIL sgn_m1 got=n%b/%h/o%b exp=n1/0001/o0", neg, bcd, overflow);
    end
    num = 16'h8000;
    repeat (LAT + 1) @(negedge clk);
    total++; if (neg !== 1'b1 || bcd !== 16'h9999 || overflow !== 1'b1) begin
      bad++; $display("FAIL sgn_min got=n%b/%h/o%b exp=n1/9999/o1", neg, bcd, overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_change_during_busy();
    test_reset_mid();
`ifdef BCD_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
